// File: rtl/guess_pkg.sv
// Shared constants and types for the guess input path and the LED display driver.
package guess_pkg;

  // Width of the slide-switch / one-hot bus.
  localparam int SW_W  = 16;
  // Width of an encoded guess value.
  localparam int VAL_W = 4;
  // Popcount of a 16-bit bus needs 5 bits (0..16).
  localparam int POP_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } guess_state_t;

endpackage : guess_pkg

// File: rtl/onehot16_encoder.sv
// Combinational one-hot to index encoder with zero / one-hot / multi-hot flags.
// For a multi-hot input the index reports the highest set bit; callers are
// expected to qualify index with is_onehot.
module onehot16_encoder
  import guess_pkg::*;
(
  input  logic [15:0] code,
  output logic [3:0]  index,
  output logic        is_zero,
  output logic        is_onehot,
  output logic        is_multi
);

  logic [POP_W-1:0] popcnt;

  // Scan every bit once: accumulate the popcount and remember the set position.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    index  = '0;
    popcnt = '0;
    for (int i = 0; i < SW_W; i++) begin
      if (code[i]) begin
        index  = VAL_W'(i);
        popcnt = popcnt + POP_W'(1);
      end
    end
  end

  // Only the "none", "exactly one" and "two or more" classes are consumed.
  always_comb begin
    is_zero   = (popcnt == POP_W'(0));
    is_onehot = (popcnt == POP_W'(1));
    is_multi  = (popcnt >= POP_W'(2));
  end

endmodule : onehot16_encoder

// File: rtl/switch_guess_encoder.sv
// Slide switches -> synchronised, debounced, encoded 4-bit guess with a
// one-cycle valid strobe. One event per press; all switches must return to
// zero before the next event can fire.
module switch_guess_encoder
  import guess_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw,
  output logic [3:0]  guess,
  output logic        guess_valid,
  output logic        multi_err,
  output logic        busy
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser stages.
  logic [SW_W-1:0] sync1;
  logic [SW_W-1:0] s;

  // Debouncer state.
  logic [SW_W-1:0]  cand;
  logic [SW_W-1:0]  stable;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hold_len;
  logic             accept;

  // Encoder results on the debounced bus.
  logic [VAL_W-1:0] enc_index;
  logic             enc_zero;
  logic             enc_onehot;
  logic             enc_multi;

  // FSM and registered outputs.
  guess_state_t     state;
  guess_state_t     state_n;
  logic [VAL_W-1:0] guess_n;
  logic             guess_valid_n;
  logic             multi_err_n;

  // Two-flop synchroniser per switch bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values; blocking here would collapse the two stages.
      sync1 <= sw;
      s     <= sync1;
    end
  end

  // hold_len is the number of edges, minus one, that s has shown the same value
  // including this one. The edge that first sees a new value counts as the
  // first, so a value is accepted on its DEBOUNCE_CYCLES-th consecutive edge.
  always_comb begin
    hold_len = (s != cand) ? '0 : cnt + CNT_W'(1);
    accept   = (s != stable) && (hold_len == CNT_LAST);
  end

  // Debouncer: any change in s restarts the run; a run equal to stable idles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand   <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      if (s != cand) begin
        cand <= s;
      end
      if (accept) begin
        stable <= s;
        cnt    <= '0;
      end else if (s == stable) begin
        cnt <= '0;
      end else begin
        cnt <= hold_len;
      end
    end
  end

  onehot16_encoder u_enc (
    .code      (stable),
    .index     (enc_index),
    .is_zero   (enc_zero),
    .is_onehot (enc_onehot),
    .is_multi  (enc_multi)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      guess       <= '0;
      guess_valid <= 1'b0;
      multi_err   <= 1'b0;
    end else begin
      state       <= state_n;
      guess       <= guess_n;
      guess_valid <= guess_valid_n;
      multi_err   <= multi_err_n;
    end
  end

  // Next-state logic: fire once on leaving zero, ignore everything until release.
  always_comb begin
    state_n       = state;
    guess_n       = guess;
    guess_valid_n = 1'b0;
    multi_err_n   = multi_err;
    unique case (state)
      IDLE: begin
        if (enc_onehot) begin
          guess_n       = enc_index;
          guess_valid_n = 1'b1;
          state_n       = HELD;
        end else if (enc_multi) begin
          multi_err_n = 1'b1;
          state_n     = HELD;
        end
      end
      HELD: begin
        if (enc_zero) begin
          multi_err_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // busy follows the state register directly so reset clears it immediately.
  always_comb begin
    busy = (state == HELD);
  end

endmodule : switch_guess_encoder

// File: tb/tb_switch_guess_encoder.sv
// Directed bench for switch_guess_encoder with DEBOUNCE_CYCLES = 4.
// Expected strobes (value and cycle) go into a queue at stimulus time; a
// separate monitor pops one entry for every guess_valid the DUT presents.
module tb_switch_guess_encoder;

  localparam int D   = 4;
  localparam int LAT = D + 3;  // cycle counter offset from drive to visible output

  typedef struct {
    logic [3:0] g;
    int         cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] sw;
  logic [3:0]  guess;
  logic        guess_valid;
  logic        multi_err;
  logic        busy;

  int   cyc;
  int   total;
  int   bad;
  exp_t q[$];
  bit   done;

  switch_guess_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .guess       (guess),
    .guess_valid (guess_valid),
    .multi_err   (multi_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive sw just after a rising edge; returns the cycle count at drive time.
  task automatic drive(input logic [15:0] v, output int t);
    @(posedge clk);
    #1;
    sw = v;
    t  = cyc;
  endtask

  task automatic wait_cyc(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press_onehot(input logic [15:0] v, input logic [3:0] g);
    int t;
    drive(v, t);
    q.push_back('{g: g, cyc: t + LAT});
    wait_cyc(t + LAT - 1);
    check("busy_before_press", busy, 1'b0);
    wait_cyc(t + LAT);
    check("busy_after_press", busy, 1'b1);
    check("guess_after_press", guess, g);
  endtask

  task automatic release_all();
    int t;
    drive(16'h0000, t);
    wait_cyc(t + LAT - 1);
    check("busy_before_release", busy, 1'b1);
    wait_cyc(t + LAT);
    check("busy_after_release", busy, 1'b0);
    check("err_after_release", multi_err, 1'b0);
  endtask

  // Monitor: every strobe must match the oldest expected entry, value and cycle.
  initial begin
    @(negedge clk);
    while (!done) begin
      if (guess_valid === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", {28'h0, guess}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("strobe_guess", guess, e.g);
          check("strobe_cycle", cyc, e.cyc);
        end
      end
      @(negedge clk);
    end
  end

  initial begin
    int t;
    cyc   = 0;
    total = 0;
    bad   = 0;
    done  = 1'b0;
    rst_n = 1'b0;
    sw    = 16'h0000;

    // Reset values, then synchronous-looking release.
    repeat (3) @(negedge clk);
    check("rst_guess", guess, 4'h0);
    check("rst_valid", guess_valid, 1'b0);
    check("rst_err", multi_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_guess", guess, 4'h0);

    // Clean presses including both ends of the range.
    press_onehot(16'h0020, 4'h5);
    release_all();
    press_onehot(16'h0001, 4'h0);
    release_all();
    press_onehot(16'h8000, 4'hF);
    release_all();

    // Bounce 0 <-> 0x0100 every 2 cycles, finish holding 0x0100.
    for (int i = 0; i <= 10; i++) begin
      drive((i % 2 == 0) ? 16'h0100 : 16'h0000, t);
      if (i != 10) @(posedge clk);
    end
    q.push_back('{g: 4'h8, cyc: t + LAT});
    wait_cyc(t + LAT);
    check("bounce_busy", busy, 1'b1);
    check("bounce_guess", guess, 4'h8);
    release_all();

    // Multi-hot: error flag, no strobe, guess kept.
    drive(16'h0003, t);
    wait_cyc(t + LAT - 1);
    check("multi_err_early", multi_err, 1'b0);
    wait_cyc(t + LAT);
    check("multi_err_set", multi_err, 1'b1);
    check("multi_busy", busy, 1'b1);
    check("multi_guess_kept", guess, 4'h8);
    release_all();

    // Change while held is ignored; a fresh press afterwards fires.
    press_onehot(16'h0004, 4'h2);
    drive(16'h0010, t);
    wait_cyc(t + LAT + 4);
    check("held_change_guess", guess, 4'h2);
    check("held_change_busy", busy, 1'b1);
    check("held_change_err", multi_err, 1'b0);
    release_all();
    press_onehot(16'h0010, 4'h4);
    release_all();

    // Reset while a switch is held: immediate clear, then a fresh strobe.
    press_onehot(16'h0400, 4'hA);
    wait_cyc(cyc + 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_guess", guess, 4'h0);
    check("async_rst_valid", guess_valid, 1'b0);
    repeat (2) @(negedge clk);
    check("in_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    t = cyc;
    q.push_back('{g: 4'hA, cyc: t + LAT});
    wait_cyc(t + LAT - 1);
    check("requal_busy_early", busy, 1'b0);
    wait_cyc(t + LAT);
    check("requal_busy", busy, 1'b1);
    check("requal_guess", guess, 4'hA);
    release_all();

    // Drain any outstanding expectations within a bounded window.
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 0);
    repeat (2) @(negedge clk);
    done = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_switch_guess_encoder
